// File: rtl/ecc_pkg.sv
// Shared types and width helpers for the SECDED SRAM controller.
// Codeword bit 0 is overall parity; bit i>0 is Hamming position i.
package ecc_pkg;

   // Smallest P with 2^P >= dw + P + 1.
   function automatic int calc_p(input int dw);
      int p;
      p = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << p) < dw + p + 1) p = i + 1;
      end
      return p;
   endfunction

   function automatic int code_width(input int dw);
      return dw + calc_p(dw) + 1;
   endfunction

   // Hamming position of data bit k (skips power-of-two slots).
   function automatic int data_pos(input int k);
      int n;
      int pos;
      n = 0;
      pos = 0;
      for (int p = 1; p < 1024; p++) begin
         if (((p & (p - 1)) != 0) && (pos == 0)) begin
            if (n == k) pos = p;
            n++;
         end
      end
      return pos;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DECODE,
      ST_WRBACK,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      DEC_CLEAN,
      DEC_CORRECTED,
      DEC_UNCORR
   } dec_e;

endpackage

// File: rtl/secded_codec.sv
// Combinational SECDED encoder and decoder (extended Hamming code).
// Shared by the write path and the read decode path.
module secded_codec
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   localparam int P  = calc_p(DATA_WIDTH),
   localparam int CW = code_width(DATA_WIDTH)
) (
   input  logic [DATA_WIDTH-1:0] enc_data_i,
   output logic [CW-1:0]         enc_code_o,
   input  logic [CW-1:0]         dec_code_i,
   output logic [DATA_WIDTH-1:0] dec_data_o,
   output logic [CW-1:0]         dec_code_o,
   output logic                  dec_error_o,
   output logic                  dec_uncorr_o
);

   logic [P-1:0] enc_syn;
   logic [P-1:0] dec_syn;
   logic         dec_ovr;

   // Encode: place data, then set check bits to the data syndrome.
   always_comb begin
      enc_code_o = '0;
      enc_syn    = '0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         enc_code_o[data_pos(k)] = enc_data_i[k];
      end
      for (int pos = 1; pos < CW; pos++) begin
         if (enc_code_o[pos]) enc_syn = enc_syn ^ P'(pos);
      end
      for (int i = 0; i < P; i++) begin
         enc_code_o[1 << i] = enc_syn[i];
      end
      enc_code_o[0] = ^enc_code_o[CW-1:1];
   end

   // Decode: syndrome names the flipped position, parity splits 1 vs 2.
   always_comb begin
      dec_syn = '0;
      for (int pos = 1; pos < CW; pos++) begin
         if (dec_code_i[pos]) dec_syn = dec_syn ^ P'(pos);
      end
      dec_ovr      = ^dec_code_i;
      dec_code_o   = dec_code_i;
      dec_error_o  = dec_ovr || (dec_syn != '0);
      dec_uncorr_o = (!dec_ovr && (dec_syn != '0)) ||
                     (dec_ovr && (int'(dec_syn) >= CW));
      for (int pos = 0; pos < CW; pos++) begin
         if (dec_ovr && (dec_syn == P'(pos))) begin
            dec_code_o[pos] = ~dec_code_i[pos];
         end
      end
      dec_data_o = '0;
      for (int k = 0; k < DATA_WIDTH; k++) begin
         dec_data_o[k] = dec_code_o[data_pos(k)];
      end
   end

endmodule

// File: rtl/sram_ecc_ctrl.sv
// SECDED SRAM controller: word reads, byte-masked writes via RMW,
// optional scrub of corrected read errors.
module sram_ecc_ctrl
   import ecc_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int SCRUB      = 1,
   localparam int CODE_WIDTH = code_width(DATA_WIDTH),
   localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [MASK_WIDTH-1:0] req_wmask,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic                  mem_clk_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_write_en,
   output logic [CODE_WIDTH-1:0] mem_write_data,
   input  logic [CODE_WIDTH-1:0] mem_read_data,
   output logic                  dbg_error,
   output logic                  dbg_uncorrectable_error,
   output logic [CODE_WIDTH-1:0] dbg_flips,
   output logic                  dbg_ignore
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [MASK_WIDTH-1:0] wmask_q, wmask_d;
   logic                  write_q, write_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   dec_e                  cls_q, cls_d;

   logic [DATA_WIDTH-1:0] enc_data;
   logic [CODE_WIDTH-1:0] enc_code;
   logic [DATA_WIDTH-1:0] dec_data;
   logic [CODE_WIDTH-1:0] dec_code;
   logic                  dec_err;
   logic                  dec_unc;
   logic [DATA_WIDTH-1:0] merged;
   logic                  in_dec;

   secded_codec #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_codec (
      .enc_data_i   (enc_data),
      .enc_code_o   (enc_code),
      .dec_code_i   (mem_read_data),
      .dec_data_o   (dec_data),
      .dec_code_o   (dec_code),
      .dec_error_o  (dec_err),
      .dec_uncorr_o (dec_unc)
   );

   assign in_dec                  = (state_q == ST_DECODE);
   assign mem_write_data          = enc_code;
   assign rsp_valid               = (state_q == ST_RESP);
   assign rsp_error               = rsp_valid && (cls_q == DEC_UNCORR);
   assign rsp_rdata               = (rsp_valid && !write_q) ? data_q : '0;
   assign dbg_error               = in_dec && dec_err;
   assign dbg_uncorrectable_error = in_dec && dec_unc;
   assign dbg_flips = in_dec ? (dec_code ^ mem_read_data) : '0;

   // Byte-wise merge of new write data over the corrected old word.
   always_comb begin
      merged = data_q;
      for (int b = 0; b < MASK_WIDTH; b++) begin
         if (wmask_q[b]) merged[8*b +: 8] = wdata_q[8*b +: 8];
      end
   end

   // State and transaction context registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
         write_q <= 1'b0;
         data_q  <= '0;
         cls_q   <= DEC_CLEAN;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wmask_q <= wmask_d;
         write_q <= write_d;
         data_q  <= data_d;
         cls_q   <= cls_d;
      end
   end

   // Next state, SRAM controls and handshake outputs.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wmask_d      = wmask_q;
      write_d      = write_q;
      data_d       = data_q;
      cls_d        = cls_q;
      req_ready    = 1'b0;
      mem_clk_en   = 1'b0;
      mem_write_en = 1'b0;
      mem_addr     = '0;
      enc_data     = '0;
      dbg_ignore   = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_write && (&req_wmask)) begin
                  mem_clk_en   = 1'b1;
                  mem_write_en = 1'b1;
                  mem_addr     = req_addr;
                  enc_data     = req_wdata;
                  write_d      = 1'b1;
                  cls_d        = DEC_CLEAN;
                  state_d      = ST_RESP;
               end else if (req_write && (req_wmask == '0)) begin
                  write_d = 1'b1;
                  cls_d   = DEC_CLEAN;
                  state_d = ST_RESP;
               end else begin
                  mem_clk_en = 1'b1;
                  mem_addr   = req_addr;
                  addr_d     = req_addr;
                  wdata_d    = req_wdata;
                  wmask_d    = req_wmask;
                  write_d    = req_write;
                  state_d    = ST_DECODE;
               end
            end
         end
         ST_DECODE: begin
            dbg_ignore = 1'b0;
            data_d     = dec_data;
            if (dec_unc) begin
               cls_d   = DEC_UNCORR;
               state_d = ST_RESP;
            end else begin
               cls_d = dec_err ? DEC_CORRECTED : DEC_CLEAN;
               if (write_q || (dec_err && (SCRUB != 0))) begin
                  state_d = ST_WRBACK;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_WRBACK: begin
            mem_clk_en   = 1'b1;
            mem_write_en = 1'b1;
            mem_addr     = addr_q;
            enc_data     = write_q ? merged : data_q;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sram_ecc_ctrl.sv
// Scoreboard bench for sram_ecc_ctrl with a behavioural SRAM model
// that can inject bit flips into read data.
module tb_sram_ecc_ctrl;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int CW = 39;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [3:0]    req_wmask = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_error;
   logic          mem_clk_en;
   logic [AW-1:0] mem_addr;
   logic          mem_write_en;
   logic [CW-1:0] mem_write_data;
   logic [CW-1:0] mem_read_data;
   logic          dbg_error;
   logic          dbg_unc;
   logic [CW-1:0] dbg_flips;
   logic          dbg_ignore;

   sram_ecc_ctrl dut (
      .clk                     (clk),
      .rst                     (rst),
      .req_valid               (req_valid),
      .req_ready               (req_ready),
      .req_write               (req_write),
      .req_addr                (req_addr),
      .req_wdata               (req_wdata),
      .req_wmask               (req_wmask),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_rdata               (rsp_rdata),
      .rsp_error               (rsp_error),
      .mem_clk_en              (mem_clk_en),
      .mem_addr                (mem_addr),
      .mem_write_en            (mem_write_en),
      .mem_write_data          (mem_write_data),
      .mem_read_data           (mem_read_data),
      .dbg_error               (dbg_error),
      .dbg_uncorrectable_error (dbg_unc),
      .dbg_flips               (dbg_flips),
      .dbg_ignore              (dbg_ignore)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
      int            lat;
      int            tacc;
   } exp_t;

   exp_t          q[$];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            wr_cnt = 0;
   logic [CW-1:0] mem [1024];
   logic [CW-1:0] rd_q = '0;
   logic [CW-1:0] inj = '0;
   logic          have_first = 1'b0;
   int            first_cyc = 0;

   logic          acc_ce, acc_we;
   logic [AW-1:0] acc_addr;
   logic [CW-1:0] acc_wd;

   assign mem_read_data = rd_q;

   initial for (int i = 0; i < 1024; i++) mem[i] = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: one-cycle read latency, optional flip injection.
   always @(posedge clk) begin
      if (mem_clk_en) begin
         if (mem_write_en) begin
            mem[mem_addr] <= mem_write_data;
            wr_cnt <= wr_cnt + 1;
         end else begin
            rd_q <= mem[mem_addr] ^ inj;
         end
      end
   end

   // Reference encoder: each check bit is the parity of its coverage set.
   function automatic logic [CW-1:0] enc(input logic [DW-1:0] d);
      logic [CW-1:0] c;
      logic          p;
      int            k;
      c = '0;
      k = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            c[pos] = d[k];
            k++;
         end
      end
      for (int i = 0; i < 6; i++) begin
         p = 1'b0;
         for (int pos = 1; pos < CW; pos++) begin
            if (((pos >> i) & 1) == 1) p = p ^ c[pos];
         end
         c[1 << i] = p;
      end
      c[0] = ^c[CW-1:1];
      return c;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic expect_rsp(input logic [DW-1:0] d, input logic e,
                             input int lat, input int tacc);
      exp_t x;
      x.rdata = d;
      x.err   = e;
      x.lat   = lat;
      x.tacc  = tacc;
      q.push_back(x);
   endtask

   task automatic issue(input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [3:0] m,
                        output int tacc);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout actual=0 required=1");
      end
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_wmask = m;
      tacc      = cyc;
      #1;
      acc_ce   = mem_clk_en;
      acc_we   = mem_write_en;
      acc_addr = mem_addr;
      acc_wd   = mem_write_data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout actual=%0d pending required=0",
                  q.size());
         q.delete();
      end
   endtask

   always @(negedge rst) have_first = 1'b0;

   // Monitor: pop and compare on every response handshake.
   always @(negedge clk) begin
      if (rst && rsp_valid) begin
         if (!have_first) begin
            have_first = 1'b1;
            first_cyc  = cyc;
         end
         if (rsp_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected actual=1 required=0");
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               chk("rsp_error", 64'(rsp_error), 64'(e.err));
               chk("rsp_latency", 64'(first_cyc - e.tacc), 64'(e.lat));
            end
            have_first = 1'b0;
         end
      end
   end

   initial begin
      int t;
      int w0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_mem_clk_en", 64'(mem_clk_en), 64'd0);
      chk("rst_dbg_ignore", 64'(dbg_ignore), 64'd1);
      chk("rst_dbg_error", 64'(dbg_error), 64'd0);
      rst = 1'b1;

      // Full write then read back.
      issue(1'b1, 10'h010, 32'hDEADBEEF, 4'hF, t);
      expect_rsp(32'h0, 1'b0, 1, t);
      chk("fw_clk_en", 64'(acc_ce), 64'd1);
      chk("fw_write_en", 64'(acc_we), 64'd1);
      chk("fw_addr", 64'(acc_addr), 64'h010);
      chk("fw_data", 64'(acc_wd), 64'(enc(32'hDEADBEEF)));
      wait_done();
      issue(1'b0, 10'h010, 32'h0, 4'h0, t);
      expect_rsp(32'hDEADBEEF, 1'b0, 2, t);
      chk("rd_clk_en", 64'(acc_ce), 64'd1);
      chk("rd_write_en", 64'(acc_we), 64'd0);
      @(negedge clk);
      chk("rd_dec_ignore", 64'(dbg_ignore), 64'd0);
      chk("rd_dec_error", 64'(dbg_error), 64'd0);
      wait_done();

      // Single flip at codeword bit 5, scrubbed.
      issue(1'b1, 10'h020, 32'h12345678, 4'hF, t);
      expect_rsp(32'h0, 1'b0, 1, t);
      wait_done();
      inj = 39'h1 << 5;
      issue(1'b0, 10'h020, 32'h0, 4'h0, t);
      inj = '0;
      expect_rsp(32'h12345678, 1'b0, 3, t);
      @(negedge clk);
      chk("sf_dbg_error", 64'(dbg_error), 64'd1);
      chk("sf_dbg_unc", 64'(dbg_unc), 64'd0);
      chk("sf_dbg_flips", 64'(dbg_flips), 64'h20);
      @(negedge clk);
      chk("sf_wb_write_en", 64'(mem_write_en), 64'd1);
      chk("sf_wb_addr", 64'(mem_addr), 64'h020);
      chk("sf_wb_data", 64'(mem_write_data), 64'(enc(32'h12345678)));
      wait_done();

      // Double flip at bits 3 and 20: data bits 0 and 14 stay flipped.
      w0 = wr_cnt;
      inj = (39'h1 << 3) | (39'h1 << 20);
      issue(1'b0, 10'h020, 32'h0, 4'h0, t);
      inj = '0;
      expect_rsp(32'h12341679, 1'b1, 2, t);
      @(negedge clk);
      chk("df_dbg_unc", 64'(dbg_unc), 64'd1);
      chk("df_dbg_error", 64'(dbg_error), 64'd1);
      @(negedge clk);
      chk("df_no_write", 64'(mem_write_en), 64'd0);
      wait_done();
      chk("df_wr_cnt", 64'(wr_cnt - w0), 64'd0);

      // Partial write merge.
      issue(1'b1, 10'h030, 32'h11223344, 4'hF, t);
      expect_rsp(32'h0, 1'b0, 1, t);
      wait_done();
      issue(1'b1, 10'h030, 32'h0000AB00, 4'b0010, t);
      expect_rsp(32'h0, 1'b0, 3, t);
      chk("pw_acc_write_en", 64'(acc_we), 64'd0);
      repeat (2) @(negedge clk);
      chk("pw_wb_write_en", 64'(mem_write_en), 64'd1);
      chk("pw_wb_data", 64'(mem_write_data), 64'(enc(32'h1122AB44)));
      wait_done();
      issue(1'b0, 10'h030, 32'h0, 4'h0, t);
      expect_rsp(32'h1122AB44, 1'b0, 2, t);
      wait_done();

      // Partial write over an uncorrectable word.
      w0 = wr_cnt;
      inj = (39'h1 << 3) | (39'h1 << 20);
      issue(1'b1, 10'h030, 32'h000000FF, 4'b0001, t);
      inj = '0;
      expect_rsp(32'h0, 1'b1, 2, t);
      wait_done();
      chk("pwdf_wr_cnt", 64'(wr_cnt - w0), 64'd0);
      issue(1'b0, 10'h030, 32'h0, 4'h0, t);
      expect_rsp(32'h1122AB44, 1'b0, 2, t);
      wait_done();

      // Zero-mask write: no SRAM access.
      w0 = wr_cnt;
      issue(1'b1, 10'h030, 32'hFFFFFFFF, 4'h0, t);
      expect_rsp(32'h0, 1'b0, 1, t);
      chk("zm_clk_en", 64'(acc_ce), 64'd0);
      wait_done();
      chk("zm_wr_cnt", 64'(wr_cnt - w0), 64'd0);
      issue(1'b0, 10'h030, 32'h0, 4'h0, t);
      expect_rsp(32'h1122AB44, 1'b0, 2, t);
      wait_done();

      // Response stall, then reset mid-RESP.
      rsp_ready = 1'b0;
      issue(1'b0, 10'h010, 32'h0, 4'h0, t);
      @(negedge clk);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("st_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("st_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
         @(negedge clk);
      end
      #2;
      rst = 1'b0;
      #1;
      chk("ar_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("ar_req_ready", 64'(req_ready), 64'd1);
      chk("ar_dbg_ignore", 64'(dbg_ignore), 64'd1);
      chk("ar_mem_clk_en", 64'(mem_clk_en), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      rsp_ready = 1'b1;

      // Scrubbed word reads clean after reset.
      issue(1'b0, 10'h020, 32'h0, 4'h0, t);
      expect_rsp(32'h12345678, 1'b0, 2, t);
      @(negedge clk);
      chk("scr_dbg_error", 64'(dbg_error), 64'd0);
      wait_done();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram_ecc_ctrl.md
Name: sram_ecc_ctrl

Overview:
- SECDED-protected controller for one synchronous single-port SRAM macro.
- Accepts word read and byte-masked write requests over a valid/ready interface and drives the SRAM control lines: clk_en, addr, write_en, write_data, read_data.
- Performs read-modify-write for partial writes and optionally scrubs correctable errors.
- Emits per-decode debug feedback (error, uncorrectable, flips, ignore) consumed by the simulation memory model.

Parameters:
- ADDR_WIDTH, 10, SRAM word address width.
- DATA_WIDTH, 32, payload width; must be a multiple of 8.
- SCRUB, 1, when 1 a correctable read error is written back corrected.
- CODE_WIDTH (derived, not overridable): DATA_WIDTH+P+1, where P is the smallest value with 2^P >= DATA_WIDTH+P+1. Value is 39 for 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- req_wmask  in  DATA_WIDTH/8  byte enables (writes only).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed when valid&&ready.
- rsp_rdata  out  DATA_WIDTH  corrected read data; 0 for writes.
- rsp_error  out  1  uncorrectable error on this transaction.
- mem_clk_en  out  1  SRAM access enable.
- mem_addr  out  ADDR_WIDTH  SRAM address.
- mem_write_en  out  1  SRAM write.
- mem_write_data  out  CODE_WIDTH  encoded word.
- mem_read_data  in  CODE_WIDTH  valid the cycle after a read access.
- dbg_error  out  1  decode found any error.
- dbg_uncorrectable_error  out  1  decode found a double error.
- dbg_flips  out  CODE_WIDTH  raw XOR corrected codeword.
- dbg_ignore  out  1  no decode this cycle; other dbg outputs meaningless.

Behaviour:
- FSM states: IDLE, DECODE, WRBACK, RESP.
- Reset (async assert, synchronous release):
  - state=IDLE; all outputs 0 except dbg_ignore=1 and req_ready=1.
  - Any in-flight access is abandoned; no response is produced for it.
- req_ready = (state==IDLE). Accept cycle T is the cycle with valid&&ready in IDLE.
- In cycle T, mem_* are driven combinationally from req_*:
  - Write, mask all ones: mem_clk_en=1, mem_write_en=1, data=encode(req_wdata). Next state RESP (rsp_valid at T+1).
  - Write, mask all zero: no SRAM access. Next state RESP.
  - Read, or partial write: mem_clk_en=1, mem_write_en=0. Latch addr/wdata/wmask/op. Next state DECODE.
- DECODE (T+1):
  - Decode mem_read_data; dbg_ignore=0; dbg_* reflect the decode.
  - Register corrected data and the error class.
  - Clean read, or (correctable read with SCRUB=0): next state RESP.
  - Uncorrectable: rsp_error=1; rsp_rdata = raw data bits; no write. Next state RESP.
  - Correctable read with SCRUB=1, or partial write without an uncorrectable error: next state WRBACK.
- WRBACK (T+2):
  - mem_clk_en=1, mem_write_en=1, latched address.
  - Data = encode(corrected), or for a partial write encode(bytewise merge: mask?wdata:corrected).
  - Next state RESP.
- RESP: rsp_valid=1, held stable until rsp_ready; then state=IDLE. The next request is acceptable in the cycle after the handshake.
- mem_clk_en=0 in IDLE without a request, and always in RESP.
- dbg_ignore=1 in every state except DECODE.
- Error on check bits only: correctable; data unchanged; scrubbed when SCRUB=1.
- An all-zero codeword decodes clean.

Decomposition:
- ecc_pkg:
  - function returning P for a data width; CODE_WIDTH derivation.
  - state enum.
  - decode-class enum (CLEAN, CORRECTED, UNCORRECTABLE).
- Sub-module secded_codec (combinational), encode and decode halves:
  - encode: data -> codeword.
  - decode: codeword -> corrected data, corrected codeword, error, uncorrectable.
  - Shared by the write path and the decode path.

Test Plan:
- Full write 0xDEADBEEF @0x010, then read @0x010 -> write at T, rsp at T+1; read rsp at T+2 with rdata=0xDEADBEEF, rsp_error=0, dbg_error=0 in DECODE.
- Inject single flip at codeword bit 5 on read of 0x12345678 with SCRUB=1 -> rdata=0x12345678, dbg_error=1, dbg_flips=1<<5, WRBACK writes the clean codeword, rsp at T+3.
- Inject double flip at bits 3 and 20 -> rsp_error=1, dbg_uncorrectable_error=1, no SRAM write, rsp at T+2.
- Partial write mask=0b0010, wdata=0x0000AB00 over stored 0x11223344 -> SRAM written encode(0x1122AB44); subsequent read returns 0x1122AB44.
- Partial write where the read-back has a double error -> no write issued; rsp_error=1; stored word unchanged.
- rsp_ready held low 5 cycles, then reset asserted mid-RESP -> rsp_valid stable until reset, then 0; req_ready=1 and dbg_ignore=1 immediately under reset.
